led_trail_fader: RTL and testbench

LED_TRAIL_FADER -- requirements
Module: led_trail_fader

---
 rtl/kitt_pkg.sv | 6 +
 rtl/led_trail_fader_if.sv | 12 +
 rtl/tick_gen.sv | 25 ++
 rtl/led_trail_fader.sv | 51 +++++
 tb/tb_led_trail_fader.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kitt_pkg.sv
// Constants shared by the KITT scanner and the LED trail fader.
package kitt_pkg;
  localparam int N_LEDS      = 8;
  localparam int CLK_FREQ_HZ = 12_000_000;
  localparam int PWM_BITS    = 8;
endpackage

// File: rtl/led_trail_fader_if.sv
// Scanner-pattern in / LED drive out bundle for the trail fader.
interface led_trail_fader_if;
  import kitt_pkg::*;

  logic              EN;
  logic [N_LEDS-1:0] LED_IN;
  logic [N_LEDS-1:0] LED_OUT;
  logic              DECAY_TICK;

  modport master (output EN, LED_IN, input LED_OUT, DECAY_TICK);
  modport slave  (input EN, LED_IN, output LED_OUT, DECAY_TICK);
endinterface

// File: rtl/tick_gen.sv
// Enable-gated prescaler: counts 0..CYCLES-1 and flags the last count.
module tick_gen #(
  parameter int CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  // Masked during reset so no step can be reported while state is being cleared.
  assign TICK = EN && !RST && (count == LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (EN) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/led_trail_fader.sv
// Per-LED brightness with halving decay and PWM output, producing a fading trail
// behind the one-hot scanner position.
module led_trail_fader #(
  parameter int CLK_FREQ     = kitt_pkg::CLK_FREQ_HZ,
  parameter int DECAY_MS     = 25,
  parameter int DECAY_CYCLES = (CLK_FREQ / 1000) * DECAY_MS,
  parameter int PWM_BITS     = kitt_pkg::PWM_BITS
) (
  input  logic CLK,
  input  logic RST,
  led_trail_fader_if.slave bus
);
  import kitt_pkg::*;

  logic [PWM_BITS-1:0]              pwm_cnt;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  bri;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  bri_nxt;
  logic [N_LEDS-1:0]                pwm_on;
  logic                             tick;

  tick_gen #(.CYCLES(DECAY_CYCLES)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (bus.EN),
    .TICK (tick)
  );

  assign bus.DECAY_TICK = tick;

  // Load beats decay when the scanner lands on an LED in a tick cycle.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_led
    assign bri_nxt[i] = (bus.EN && bus.LED_IN[i]) ? {PWM_BITS{1'b1}}
                      : tick                      ? (bri[i] >> 1)
                      :                             bri[i];
    assign pwm_on[i]  = (pwm_cnt < bri[i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt     <= '0;
      bri         <= '0;
      bus.LED_OUT <= '0;
    end else begin
      bri         <= bri_nxt;
      bus.LED_OUT <= bus.EN ? pwm_on : '0;
      if (bus.EN) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_trail_fader.sv
// Self-checking bench for led_trail_fader against a cycle-level behavioural model.
module tb_led_trail_fader;
  localparam int C          = 4;
  localparam int EXP_PERIOD2 = (400_000 / 1000) * 25;

  logic CLK = 1'b0;
  logic RST;
  logic RST2;
  always #5 CLK = ~CLK;

  led_trail_fader_if bus ();
  led_trail_fader_if bus2 ();

  led_trail_fader #(.DECAY_CYCLES(C)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  led_trail_fader #(.CLK_FREQ(400_000)) dut2 (
    .CLK (CLK),
    .RST (RST2),
    .bus (bus2.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int         bri_m [8];
  int         pwm_m;
  int         presc_m;
  logic [7:0] led_out_m;
  logic       tick_o;
  logic       tick_e;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) bri_m[i] = 0;
    pwm_m = 0;
    presc_m = 0;
    led_out_m = 8'h00;
  endtask

  // Drive one cycle, record observed/expected tick, advance model, land at negedge+1.
  task automatic step(input logic r, input logic e, input logic [7:0] d);
    logic [7:0] on;
    RST = r;
    bus.EN = e;
    bus.LED_IN = d;
    #1;
    tick_o = bus.DECAY_TICK;
    tick_e = !r && e && (presc_m == C - 1);
    @(posedge CLK);
    if (r) begin
      model_clear();
    end else begin
      for (int i = 0; i < 8; i++) on[i] = (pwm_m < bri_m[i]);
      led_out_m = e ? on : 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (e && d[i]) bri_m[i] = 255;
        else if (tick_e) bri_m[i] = bri_m[i] / 2;
      end
      if (e) begin
        presc_m = (presc_m + 1) % C;
        pwm_m = (pwm_m + 1) % 256;
      end
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 8'hFF);
      checks += 3;
      if (bus.LED_OUT !== 8'h00) begin
        failures++; $display("FAIL reset_led_out got=%h exp=00", bus.LED_OUT);
      end
      if (tick_o !== 1'b0) begin
        failures++; $display("FAIL reset_tick got=%b exp=0", tick_o);
      end
      if (dut.bri !== 64'h0) begin
        failures++; $display("FAIL reset_bri got=%h exp=0", dut.bri);
      end
    end
  endtask

  task automatic test_load_full_duty();
    int high = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 512; k++) begin
      step(1'b0, 1'b1, 8'h01);
      checks++;
      if (bus.LED_OUT[7:1] !== 7'h00) begin
        failures++; $display("FAIL full_duty_other_bits cyc=%0d got=%h exp=00", k, bus.LED_OUT[7:1]);
      end
      if (k >= 256 && bus.LED_OUT[0] === 1'b1) high++;
    end
    checks += 2;
    if (high != 255) begin
      failures++; $display("FAIL full_duty_high_count got=%0d exp=255", high);
    end
    if (dut.bri[0] !== 8'd255) begin
      failures++; $display("FAIL full_duty_bri0 got=%0d exp=255", dut.bri[0]);
    end
  endtask

  task automatic test_trail();
    int exp_b = 255;
    int nt = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < 8 * C + 8 && nt < 8; k++) begin
      step(1'b0, 1'b1, 8'h02);
      checks++;
      if (bus.LED_OUT !== led_out_m) begin
        failures++; $display("FAIL trail_led_out got=%h exp=%h", bus.LED_OUT, led_out_m);
      end
      if (tick_o === 1'b1) begin
        nt++;
        exp_b = exp_b / 2;
        checks++;
        if (dut.bri[0] !== exp_b[7:0]) begin
          failures++; $display("FAIL trail_bri0 tick=%0d got=%0d exp=%0d", nt, dut.bri[0], exp_b);
        end
      end
    end
    checks += 3;
    if (nt != 8) begin
      failures++; $display("FAIL trail_tick_count got=%0d exp=8", nt);
    end
    if (dut.bri[0] !== 8'd0) begin
      failures++; $display("FAIL trail_dark got=%0d exp=0", dut.bri[0]);
    end
    if (dut.bri[1] !== 8'd255) begin
      failures++; $display("FAIL trail_bri1 got=%0d exp=255", dut.bri[1]);
    end
  endtask

  task automatic test_collision();
    int guard = 0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h08);
    while (bri_m[3] != 31 && guard < 50) begin
      step(1'b0, 1'b1, 8'h00);
      guard++;
    end
    while (presc_m != C - 1 && guard < 60) begin
      step(1'b0, 1'b1, 8'h00);
      guard++;
    end
    checks++;
    if (dut.bri[3] !== 8'd31) begin
      failures++; $display("FAIL collision_pre_bri3 got=%0d exp=31", dut.bri[3]);
    end
    step(1'b0, 1'b1, 8'h08);
    checks += 2;
    if (tick_o !== 1'b1) begin
      failures++; $display("FAIL collision_tick got=%b exp=1", tick_o);
    end
    if (dut.bri[3] !== 8'd255) begin
      failures++; $display("FAIL collision_bri3 got=%0d exp=255", dut.bri[3]);
    end
  endtask

  task automatic test_enable_freeze();
    int guard = 0;
    int held;
    int waited = 0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    while (bri_m[0] != 63 && guard < 40) begin
      step(1'b0, 1'b1, 8'h00);
      guard++;
    end
    step(1'b0, 1'b1, 8'h00);
    held = presc_m;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 8'h00);
      checks += 3;
      if (bus.LED_OUT !== 8'h00) begin
        failures++; $display("FAIL freeze_led_out cyc=%0d got=%h exp=00", k, bus.LED_OUT);
      end
      if (dut.bri[0] !== 8'd63) begin
        failures++; $display("FAIL freeze_bri0 cyc=%0d got=%0d exp=63", k, dut.bri[0]);
      end
      if (tick_o !== 1'b0) begin
        failures++; $display("FAIL freeze_tick cyc=%0d got=%b exp=0", k, tick_o);
      end
    end
    do begin
      step(1'b0, 1'b1, 8'h00);
      waited++;
    end while (tick_o !== 1'b1 && waited < 3 * C);
    checks += 2;
    if (waited != C - held) begin
      failures++; $display("FAIL freeze_resume_wait got=%0d exp=%0d", waited, C - held);
    end
    if (dut.bri[0] !== 8'd31) begin
      failures++; $display("FAIL freeze_resume_bri0 got=%0d exp=31", dut.bri[0]);
    end
  endtask

  task automatic test_reset_mid_fade();
    int waited = 0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < C + 2; k++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hA5);
    checks += 2;
    if (dut.bri !== 64'h0) begin
      failures++; $display("FAIL midfade_reset_bri got=%h exp=0", dut.bri);
    end
    if (bus.LED_OUT !== 8'h00) begin
      failures++; $display("FAIL midfade_reset_led_out got=%h exp=00", bus.LED_OUT);
    end
    do begin
      step(1'b0, 1'b1, 8'h00);
      waited++;
    end while (tick_o !== 1'b1 && waited < 3 * C);
    checks++;
    if (waited != C) begin
      failures++; $display("FAIL first_tick_after_reset got=%0d exp=%0d", waited, C);
    end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [7:0] d;
    logic [7:0] one_hot = 8'h01;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) d = 8'($urandom);
      else begin
        one_hot = {one_hot[6:0], one_hot[7]};
        d = one_hot;
      end
      step(r, e, d);
      checks += 2;
      if (tick_o !== tick_e) begin
        failures++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", k, tick_o, tick_e);
      end
      if (bus.LED_OUT !== led_out_m) begin
        failures++; $display("FAIL rand_led_out cyc=%0d got=%h exp=%h", k, bus.LED_OUT, led_out_m);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dut.bri[i] !== bri_m[i][7:0]) begin
          failures++; $display("FAIL rand_bri cyc=%0d led=%0d got=%0d exp=%0d", k, i, dut.bri[i], bri_m[i]);
        end
      end
    end
  endtask

  task automatic test_default_timing();
    int n = 0;
    int m = 0;
    RST2 = 1'b1;
    bus2.EN = 1'b1;
    bus2.LED_IN = 8'h00;
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    RST2 = 1'b0;
    while (bus2.DECAY_TICK !== 1'b1 && n < 30000) begin
      @(negedge CLK); #1;
      n++;
    end
    checks++;
    if (n + 1 != EXP_PERIOD2) begin
      failures++; $display("FAIL default_first_tick got=%0d exp=%0d", n + 1, EXP_PERIOD2);
    end
    do begin
      @(negedge CLK); #1;
      m++;
    end while (bus2.DECAY_TICK !== 1'b1 && m < 30000);
    checks++;
    if (m != EXP_PERIOD2) begin
      failures++; $display("FAIL default_tick_period got=%0d exp=%0d", m, EXP_PERIOD2);
    end
  endtask

  initial begin
    RST = 1'b1;
    RST2 = 1'b1;
    bus.EN = 1'b0;
    bus.LED_IN = 8'h00;
    bus2.EN = 1'b0;
    bus2.LED_IN = 8'h00;
    model_clear();
    @(negedge CLK); #1;
    test_reset();
    test_load_full_duty();
    test_trail();
    test_collision();
    test_enable_freeze();
    test_reset_mid_fade();
    test_random();
    test_default_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
